// File: rtl/evm_result_sequencer.sv
// ---------------------------------------------------------------------------
// evm_result_sequencer
//   Result stage of the EVM. On entry to result mode it freezes the four
//   candidate tallies, scans them one per cycle to find the winner and any tie,
//   then rotates the display through each candidate's count and the total.
//
// Ports
//   clock         system clock, rising edge
//   reset         asynchronous, active-low; clears all state
//   mode          0 = voting, 1 = result (synchronous level)
//   candN_votes   live tallies, CNT_W bits each (N = 1..4)
//   busy          high while scanning or showing
//   winner        winning candidate 1..4, 0 = none
//   winner_valid  scan complete and total > 0
//   tie           two or more candidates share a non-zero maximum
//   disp_cand     screen: 1..4 = candidate, 5 = total, 0 = blank
//   disp_value    value for the current screen
//   dbg_state     FSM state (0 = IDLE, 1 = SCAN, 2 = SHOW)
//
// Interface semantics: there is no valid/ready handshake. mode is a level;
// a rising level starts one snapshot/scan, a low level in any busy state
// aborts back to IDLE on the next edge. All outputs are registered.
// ---------------------------------------------------------------------------
module evm_result_sequencer #(
  parameter int CNT_W = 8,
  parameter int DWELL = 50000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mode,
  input  logic [CNT_W-1:0] cand1_votes,
  input  logic [CNT_W-1:0] cand2_votes,
  input  logic [CNT_W-1:0] cand3_votes,
  input  logic [CNT_W-1:0] cand4_votes,
  output logic             busy,
  output logic [2:0]       winner,
  output logic             winner_valid,
  output logic             tie,
  output logic [2:0]       disp_cand,
  output logic [CNT_W-1:0] disp_value,
  output logic [1:0]       dbg_state
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_mode_d;
  logic [CNT_W-1:0] r_snap [4];
  logic [CNT_W+1:0] r_total;
  logic [CNT_W-1:0] r_max;
  logic [2:0]       r_win;
  logic             r_tie;
  logic [1:0]       r_idx;
  logic [DW_W-1:0]  r_dwell;

  logic             w_rise;
  logic [CNT_W+1:0] w_sum;
  logic [CNT_W-1:0] w_total_sat;
  logic [2:0]       w_next_cand;
  logic [1:0]       w_next_idx;
  logic [CNT_W-1:0] w_next_val;
  logic [CNT_W-1:0] w_cur;

  assign w_rise    = mode & ~r_mode_d;
  assign dbg_state = r_state;
  assign w_cur     = r_snap[r_idx];

  assign w_sum = {2'b00, cand1_votes} + {2'b00, cand2_votes}
               + {2'b00, cand3_votes} + {2'b00, cand4_votes};

  // Total screen saturates when the sum no longer fits in CNT_W bits.
  assign w_total_sat = (|r_total[CNT_W+1:CNT_W]) ? {CNT_W{1'b1}} : r_total[CNT_W-1:0];

  // Next screen after the current one; 5 wraps back to 1. Screen n shows
  // snapshot entry n-1, so the low two bits minus one give the index.
  always_comb begin
    w_next_cand = (disp_cand == 3'd5) ? 3'd1 : disp_cand + 3'd1;
    w_next_idx  = w_next_cand[1:0] - 2'd1;
    w_next_val  = (w_next_cand == 3'd5) ? w_total_sat : r_snap[w_next_idx];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_mode_d     <= 1'b0;
      for (int i = 0; i < 4; i++) r_snap[i] <= '0;
      r_total      <= '0;
      r_max        <= '0;
      r_win        <= '0;
      r_tie        <= 1'b0;
      r_idx        <= '0;
      r_dwell      <= '0;
      busy         <= 1'b0;
      winner       <= '0;
      winner_valid <= 1'b0;
      tie          <= 1'b0;
      disp_cand    <= '0;
      disp_value   <= '0;
    end else begin
      r_mode_d <= mode;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_snap[0] <= cand1_votes;
            r_snap[1] <= cand2_votes;
            r_snap[2] <= cand3_votes;
            r_snap[3] <= cand4_votes;
            r_total   <= w_sum;
            r_max     <= '0;
            r_win     <= '0;
            r_tie     <= 1'b0;
            r_idx     <= '0;
            busy      <= 1'b1;
            r_state   <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (!mode) begin
            // Abort: partial scan is discarded.
            r_state      <= ST_IDLE;
            busy         <= 1'b0;
            winner       <= '0;
            winner_valid <= 1'b0;
            tie          <= 1'b0;
            disp_cand    <= '0;
            disp_value   <= '0;
          end else begin
            // Strict greater-than keeps the lowest index on equal maxima.
            if (w_cur > r_max) begin
              r_max <= w_cur;
              r_win <= {1'b0, r_idx} + 3'd1;
              r_tie <= 1'b0;
            end else if ((w_cur == r_max) && (r_max != '0)) begin
              r_tie <= 1'b1;
            end
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_state    <= ST_SHOW;
              disp_cand  <= 3'd1;
              disp_value <= r_snap[0];
              r_dwell    <= '0;
            end
          end
        end

        ST_SHOW: begin
          if (!mode) begin
            r_state      <= ST_IDLE;
            busy         <= 1'b0;
            winner       <= '0;
            winner_valid <= 1'b0;
            tie          <= 1'b0;
            disp_cand    <= '0;
            disp_value   <= '0;
          end else begin
            // Scan results become visible on the first SHOW edge and hold.
            winner       <= r_win;
            winner_valid <= (r_max != '0);
            tie          <= r_tie;
            if (r_dwell == DWELL_LAST) begin
              r_dwell    <= '0;
              disp_cand  <= w_next_cand;
              disp_value <= w_next_val;
            end else begin
              r_dwell <= r_dwell + 1'b1;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_evm_result_sequencer.sv
module tb_evm_result_sequencer;
  localparam int CW = 8;
  localparam int DW = 3;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          mode  = 1'b0;
  logic [CW-1:0] c1 = '0, c2 = '0, c3 = '0, c4 = '0;
  logic          busy, winner_valid, tie;
  logic [2:0]    winner, disp_cand;
  logic [CW-1:0] disp_value;
  logic [1:0]    dbg_state;

  always #5 clock = ~clock;

  evm_result_sequencer #(.CNT_W(CW), .DWELL(DW)) dut (
    .clock(clock), .reset(reset), .mode(mode),
    .cand1_votes(c1), .cand2_votes(c2), .cand3_votes(c3), .cand4_votes(c4),
    .busy(busy), .winner(winner), .winner_valid(winner_valid), .tie(tie),
    .disp_cand(disp_cand), .disp_value(disp_value), .dbg_state(dbg_state)
  );

  // Observed outputs packed as {busy, winner, valid, tie, disp_cand, disp_value}.
  logic [16:0] obs;
  assign obs = {busy, winner, winner_valid, tie, disp_cand, disp_value};

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // Tallies frozen by the most recent start; k = edges after the rise edge (0 = rise edge).
  int snap [4];
  logic [16:0] exp_q[$];

  function automatic logic [16:0] model(input int k);
    int mx, w, cnt, tot, s, dc, dv;
    logic b, v, t;
    mx = 0; w = 0; cnt = 0; tot = 0; dc = 0; dv = 0; v = 0; t = 0;
    for (int i = 0; i < 4; i++) begin
      tot += snap[i];
      if (snap[i] > mx) begin mx = snap[i]; w = i + 1; end
    end
    for (int i = 0; i < 4; i++) if (mx > 0 && snap[i] == mx) cnt++;
    b = 1'b1;
    if (k < 5) w = 0;
    else begin v = (mx > 0); t = (cnt >= 2); end
    if (k >= 4) begin
      s  = ((k - 4) / DW) % 5;
      dc = s + 1;
      dv = (s == 4) ? ((tot > 255) ? 255 : tot) : snap[s];
    end
    return {b, 3'(w), v, t, 3'(dc), 8'(dv)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input int a, input int b, input int c, input int d);
    c1 = 8'(a); c2 = 8'(b); c3 = 8'(c); c4 = 8'(d);
    snap[0] = a; snap[1] = b; snap[2] = c; snap[3] = d;
    mode = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    n_vec++;
    if (obs !== 17'd0) begin
      n_err++; $display("FAIL reset_outputs got=%h exp=%h", obs, 17'd0);
    end
    n_vec++;
    if (dbg_state !== 2'd0) begin
      n_err++; $display("FAIL reset_state got=%0d exp=0", dbg_state);
    end
    reset = 1'b1;
    step();
    n_vec++;
    if (obs !== 17'd0) begin
      n_err++; $display("FAIL idle_after_reset got=%h exp=%h", obs, 17'd0);
    end
  endtask

  task automatic test_scan(input string name, input int a, input int b, input int c,
                           input int d, input int ncyc);
    logic [16:0] e;
    start(a, b, c, d);
    for (int k = 0; k < ncyc; k++) begin
      step();
      exp_q.push_back(model(k));
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++; $display("FAIL %s k=%0d got=%h exp=%h", name, k, obs, e);
      end
    end
    mode = 1'b0;
    step();
    n_vec++;
    if (obs !== 17'd0) begin
      n_err++; $display("FAIL %s_drop got=%h exp=%h", name, obs, 17'd0);
    end
    step();
  endtask

  task automatic test_random();
    int a, b, c, d;
    for (int r = 0; r < 8; r++) begin
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 1) == 1) ? a : $urandom_range(0, 255);
      c = $urandom_range(0, 255);
      d = ($urandom_range(0, 2) == 0) ? c : $urandom_range(0, 255);
      test_scan("random", a, b, c, d, $urandom_range(3, 24));
    end
  endtask

  task automatic test_snapshot_freeze();
    logic [16:0] e;
    start(11, 22, 33, 44);
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 6) c3 = 8'd99;  // live change after snapshot
      e = model(k);
      n_vec++;
      if (obs !== e) begin
        n_err++; $display("FAIL freeze k=%0d got=%h exp=%h", k, obs, e);
      end
    end
    mode = 1'b0;
    step();
    n_vec++;
    if (obs !== 17'd0) begin
      n_err++; $display("FAIL freeze_drop got=%h exp=%h", obs, 17'd0);
    end
    step();
    test_scan("resnap", 11, 22, 99, 44, 14);
  endtask

  task automatic test_back_to_back();
    logic [16:0] e;
    start(5, 1, 5, 2);
    repeat (6) step();
    mode = 1'b0;
    step();
    n_vec++;
    if (obs !== 17'd0) begin
      n_err++; $display("FAIL b2b_fall got=%h exp=%h", obs, 17'd0);
    end
    test_scan("b2b_rise", 1, 6, 2, 6, 10);
  endtask

  task automatic test_async_reset();
    logic [16:0] e;
    start(8, 3, 8, 9);
    repeat (2) step();
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (obs !== 17'd0) begin
      n_err++; $display("FAIL async_scan got=%h exp=%h", obs, 17'd0);
    end
    step();
    start(7, 7, 2, 1);  // mode stays high through release
    reset = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      e = model(k);
      n_vec++;
      if (obs !== e) begin
        n_err++; $display("FAIL rst_scan_restart k=%0d got=%h exp=%h", k, obs, e);
      end
    end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (obs !== 17'd0) begin
      n_err++; $display("FAIL async_show got=%h exp=%h", obs, 17'd0);
    end
    step();
    start(0, 40, 3, 41);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      e = model(k);
      n_vec++;
      if (obs !== e) begin
        n_err++; $display("FAIL rst_show_restart k=%0d got=%h exp=%h", k, obs, e);
      end
    end
    mode = 1'b0;
    repeat (2) step();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_scan("winner_basic", 3, 7, 2, 5, 8);
    test_scan("tie_4_9_9_1", 4, 9, 9, 1, 8);
    test_scan("all_zero", 0, 0, 0, 0, 12);
    test_scan("display_rotation", 10, 20, 30, 40, 25);
    test_scan("total_saturate", 200, 200, 10, 0, 21);
    test_random();
    test_snapshot_freeze();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
